// File: rtl/ball_engine.sv
// Ball physics and renderer for the paddle game.
// Steps the ball once per frame tick, bounces it off the walls and the paddle,
// reports misses and a saturating hit count, and renders a registered ball pixel.
module ball_engine #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned BALL_SIZE    = 8,
    parameter int unsigned SPEED        = 2,
    parameter int unsigned PADDLE_Y     = 464,
    parameter int unsigned PADDLE_W     = 64,
    parameter int unsigned START_X      = 316,
    parameter int unsigned START_Y      = 100,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic       clck,
    input  logic       reset_n,
    input  logic       update,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic [9:0] paddle_x,
    output logic       ball_pixel,
    output logic       miss,
    output logic [7:0] hits,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y
);

    localparam int unsigned CntW = $clog2(SERVE_FRAMES + 1);

    // All geometry compares run at 11 bits so sums never wrap.
    localparam logic [10:0] XMax  = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] YMiss = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Spd   = 11'(SPEED);
    localparam logic [10:0] Size  = 11'(BALL_SIZE);
    localparam logic [10:0] PadY  = 11'(PADDLE_Y);
    localparam logic [10:0] PadW  = 11'(PADDLE_W);

    localparam logic [0:0] StServe = 1'b0;
    localparam logic [0:0] StMove  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [CntW-1:0] serve_cnt_q, serve_cnt_d;
    logic [9:0]      bx_q, bx_d;
    logic [8:0]      by_q, by_d;
    logic            dx_q, dx_d;
    logic            dy_q, dy_d;
    logic [7:0]      hits_q, hits_d;
    logic            miss_q, miss_d;
    logic            pix_q, pix_d;
    logic            update_q;

    logic            step;
    logic [10:0]     bx_ext, by_ext, px_ext, x_ext, y_ext;
    logic [10:0]     bx_new;
    logic            dx_new;
    logic            paddle_hit, floor_miss;

    assign step   = update & ~update_q;
    assign bx_ext = {1'b0, bx_q};
    assign by_ext = {2'b0, by_q};
    assign px_ext = {1'b0, paddle_x};
    assign x_ext  = {1'b0, x};
    assign y_ext  = {2'b0, y};

    // Horizontal candidate position and wall bounce, from pre-step values
    always_comb begin
        bx_new = bx_ext;
        dx_new = dx_q;
        if (dx_q) begin
            if (bx_ext + Spd >= XMax) begin
                bx_new = XMax;
                dx_new = 1'b0;
            end else begin
                bx_new = bx_ext + Spd;
            end
        end else begin
            if (bx_ext <= Spd) begin
                bx_new = '0;
                dx_new = 1'b1;
            end else begin
                bx_new = bx_ext - Spd;
            end
        end
    end

    // Paddle overlap uses the new x so a bounce and a hit in one step both count
    assign paddle_hit = (by_ext + Size <= PadY) && (by_ext + Size + Spd >= PadY) &&
                        (bx_new + Size > px_ext) && (bx_new < px_ext + PadW);
    assign floor_miss = (by_ext + Spd >= YMiss);

    // Serve countdown and per-frame ball motion
    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        bx_d        = bx_q;
        by_d        = by_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        hits_d      = hits_q;
        miss_d      = 1'b0;
        if (step) begin
            if (state_q == StServe) begin
                serve_cnt_d = serve_cnt_q - CntW'(1);
                if (serve_cnt_q == CntW'(1)) begin
                    state_d = StMove;
                end
            end else begin
                bx_d = bx_new[9:0];
                dx_d = dx_new;
                if (!dy_q) begin
                    if (by_ext <= Spd) begin
                        by_d = '0;
                        dy_d = 1'b1;
                    end else begin
                        by_d = by_q - 9'(SPEED);
                    end
                end else if (paddle_hit) begin
                    by_d   = 9'(PADDLE_Y - BALL_SIZE);
                    dy_d   = 1'b0;
                    hits_d = (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;
                end else if (floor_miss) begin
                    miss_d      = 1'b1;
                    hits_d      = '0;
                    bx_d        = 10'(START_X);
                    by_d        = 9'(START_Y);
                    dx_d        = 1'b1;
                    dy_d        = 1'b1;
                    serve_cnt_d = CntW'(SERVE_FRAMES);
                    state_d     = StServe;
                end else begin
                    by_d = by_q + 9'(SPEED);
                end
            end
        end
    end

    // Raster hit test; left/top inclusive, right/bottom exclusive, hidden while serving
    always_comb begin
        pix_d = (state_q == StMove) &&
                (x_ext >= bx_ext) && (x_ext < bx_ext + Size) &&
                (y_ext >= by_ext) && (y_ext < by_ext + Size);
    end

    // State registers with asynchronous reset to the serve condition
    always_ff @(posedge clck or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StServe;
            serve_cnt_q <= CntW'(SERVE_FRAMES);
            bx_q        <= 10'(START_X);
            by_q        <= 9'(START_Y);
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            hits_q      <= '0;
            miss_q      <= 1'b0;
            pix_q       <= 1'b0;
            update_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            hits_q      <= hits_d;
            miss_q      <= miss_d;
            pix_q       <= pix_d;
            update_q    <= update;
        end
    end

    assign ball_pixel = pix_q;
    assign miss       = miss_q;
    assign hits       = hits_q;
    assign ball_x     = bx_q;
    assign ball_y     = by_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: serve timing, wall and paddle bounces, miss,
// pixel window edges, update edge detection and asynchronous reset.
module tb_ball_engine;

    logic       clck;
    logic       reset_n;
    logic       update;
    logic [9:0] x;
    logic [8:0] y;
    logic [9:0] paddle_x;
    logic       ball_pixel;
    logic       miss;
    logic [7:0] hits;
    logic [9:0] ball_x;
    logic [8:0] ball_y;

    int n_checks = 0;
    int n_errors = 0;
    int miss_cnt = 0;
    logic last_miss;
    logic pix_seen;

    ball_engine dut (
        .clck       (clck),
        .reset_n    (reset_n),
        .update     (update),
        .x          (x),
        .y          (y),
        .paddle_x   (paddle_x),
        .ball_pixel (ball_pixel),
        .miss       (miss),
        .hits       (hits),
        .ball_x     (ball_x),
        .ball_y     (ball_y)
    );

    initial clck = 1'b0;
    always #5 clck = ~clck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One-cycle update pulse; returns on the negedge after the stepping edge
    task automatic do_step();
        @(negedge clck) update = 1'b1;
        @(negedge clck) update = 1'b0;
        last_miss = miss;
        if (miss) miss_cnt++;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) do_step();
    endtask

    task automatic reset_pulse();
        @(negedge clck) reset_n = 1'b0;
        @(negedge clck) reset_n = 1'b1;
        miss_cnt = 0;
    endtask

    initial begin
        reset_n  = 1'b0;
        update   = 1'b0;
        x        = 10'd316;
        y        = 9'd100;
        paddle_x = 10'd560;
        repeat (2) @(negedge clck);
        check("rst_ball_x", ball_x, 316);
        check("rst_ball_y", ball_y, 100);
        check("rst_hits", hits, 0);
        check("rst_miss", miss, 0);
        check("rst_pixel", ball_pixel, 0);
        reset_n = 1'b1;

        // Serve: raster sits on the ball, yet it stays hidden for 60 steps
        pix_seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            do_step();
            pix_seen |= ball_pixel;
        end
        check("serve_pixel", pix_seen, 0);
        check("serve_no_move_x", ball_x, 316);
        check("serve_no_move_y", ball_y, 100);
        do_step();
        check("move1_x", ball_x, 318);
        check("move1_y", ball_y, 102);

        // Pixel window around (318,102)
        @(negedge clck) begin x = 10'd318; y = 9'd102; end
        @(negedge clck) check("pix_top_left", ball_pixel, 1);
        x = 10'd325; y = 9'd109;
        @(negedge clck) check("pix_bottom_right", ball_pixel, 1);
        x = 10'd326; y = 9'd102;
        @(negedge clck) check("pix_right_excl", ball_pixel, 0);
        x = 10'd317;
        @(negedge clck) check("pix_left_out", ball_pixel, 0);
        x = 10'd318; y = 9'd110;
        @(negedge clck) check("pix_bottom_excl", ball_pixel, 0);
        x = 10'd0; y = 9'd0;

        // Held-high update: one step only
        @(negedge clck) update = 1'b1;
        repeat (10) @(negedge clck);
        update = 1'b0;
        @(negedge clck);
        check("hold_x", ball_x, 320);
        check("hold_y", ball_y, 104);

        // Right wall at move 158, then heading left
        run_steps(156);
        check("wall_x", ball_x, 632);
        do_step();
        check("after_wall_x", ball_x, 630);
        check("after_wall_y", ball_y, 418);

        // Paddle hit at move 178
        run_steps(19);
        check("hit_y", ball_y, 456);
        check("hit_x", ball_x, 592);
        check("hit_cnt", hits, 1);
        check("hit_no_miss", miss_cnt, 0);
        do_step();
        check("rise_y", ball_y, 454);
        check("rise_x", ball_x, 590);

        // Ball climbs, bounces off top and left, falls back past a moved paddle
        paddle_x = 10'd0;
        run_steps(462);
        check("fall_y", ball_y, 470);
        check("fall_x", ball_x, 334);
        check("fall_hits", hits, 1);
        check("fall_no_miss", miss_cnt, 0);
        do_step();
        check("miss_pulse", last_miss, 1);
        check("miss_hits_clr", hits, 0);
        check("miss_ball_x", ball_x, 316);
        check("miss_ball_y", ball_y, 100);
        x = 10'd316; y = 9'd100;
        @(negedge clck) check("miss_pulse_end", miss, 0);
        @(negedge clck) check("miss_pixel", ball_pixel, 0);

        // Fresh run with the paddle out of the way
        reset_pulse();
        run_steps(60 + 185);
        check("r2_fall_y", ball_y, 470);
        check("r2_fall_x", ball_x, 578);
        do_step();
        check("r2_miss", last_miss, 1);
        check("r2_ball_x", ball_x, 316);
        check("r2_ball_y", ball_y, 100);
        check("r2_miss_cnt", miss_cnt, 1);

        // Asynchronous reset mid-move
        reset_pulse();
        run_steps(60 + 3);
        x = 10'd322; y = 9'd106;
        @(negedge clck);
        @(negedge clck) check("pre_rst_pixel", ball_pixel, 1);
        check("pre_rst_x", ball_x, 322);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_x", ball_x, 316);
        check("async_rst_y", ball_y, 100);
        check("async_rst_pixel", ball_pixel, 0);
        check("async_rst_miss", miss, 0);
        check("async_rst_hits", hits, 0);
        @(negedge clck) reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
